bubble_motion_ctrl: RTL and testbench

Per-bubble motion controller that drives the position and size inputs of the adjustable-size square drawing object. It is the producer side of that interface (topLeftX, topLeftY, size).
- Integrates horizontal motion and gravity once per video frame, in fixed point.
- Bounces off the floor and the side walls.
- Reacts to a rope hit: the bubble either splits into a smaller bubble plus a sibling-spawn request, or dies.
- Sits between the game-control/collision logic and the drawing object.

---
 rtl/bubble_pkg.sv | 32 +++
 rtl/bubble_axis_step.sv | 52 +++++
 rtl/bubble_motion_ctrl.sv | 167 ++++++++++++++++
 tb/tb_bubble_motion_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bubble_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bubble_pkg
// Description : Shared FSM states, fixed-point constants and size helpers
//               for the bubble motion controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bubble_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        SPLIT  = 2'd2
    } state_t;

    localparam int FIXED_SHIFT  = 6;
    localparam int MAX_SIZE     = 3;
    localparam int BASE_SIZE_PX = 8;
    localparam int BOUNCE_BASE  = 320;
    localparam int BOUNCE_STEP  = 64;
    localparam int POS_W        = 19;

    function automatic logic [10:0] edge_px(input logic [2:0] sz);
        edge_px = 11'(BASE_SIZE_PX << sz);
    endfunction

    function automatic logic signed [POS_W-1:0] bounce_speed(input logic [2:0] sz);
        bounce_speed = POS_W'(BOUNCE_BASE + BOUNCE_STEP * int'(sz));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bubble_axis_step.sv
`default_nettype none
// ============================================================================
// Module      : bubble_axis_step
// Description : One-axis fixed-point integration step with speed saturation
//               and reflection against a low and a high position bound.
// Revision    : 1.0 - initial release
// ============================================================================
module bubble_axis_step
    import bubble_pkg::*;
#(
    parameter bit HI_INCLUSIVE = 1'b0
) (
    input  logic signed [POS_W-1:0] i_pos,
    input  logic signed [POS_W-1:0] i_spd,
    input  logic signed [POS_W-1:0] i_accel,
    input  logic signed [POS_W-1:0] i_max_spd,
    input  logic signed [POS_W-1:0] i_lo,
    input  logic signed [POS_W-1:0] i_hi,
    input  logic signed [POS_W-1:0] i_hi_bounce_spd,
    output logic signed [POS_W-1:0] o_pos_next,
    output logic signed [POS_W-1:0] o_spd_next
);

    logic signed [POS_W-1:0] w_pos_mv;
    logic signed [POS_W-1:0] w_spd_acc;
    logic                    w_spd_neg;
    logic                    w_spd_pos;
    logic                    w_hit_hi;

    always_comb begin
        w_pos_mv  = i_pos + i_spd;
        w_spd_acc = i_spd + i_accel;
        if (w_spd_acc > i_max_spd) begin
            w_spd_acc = i_max_spd;
        end
        w_spd_neg  = w_spd_acc[POS_W-1];
        w_spd_pos  = !w_spd_acc[POS_W-1] && (|w_spd_acc);
        w_hit_hi   = HI_INCLUSIVE ? (w_pos_mv >= i_hi) : (w_pos_mv > i_hi);
        o_pos_next = w_pos_mv;
        o_spd_next = w_spd_acc;
        // Speed sign gates the bounce so a body already leaving a bound is not re-captured.
        if ((w_pos_mv < i_lo) && w_spd_neg) begin
            o_pos_next = i_lo;
            o_spd_next = -w_spd_acc;
        end else if (w_hit_hi && w_spd_pos) begin
            o_pos_next = i_hi;
            o_spd_next = i_hi_bounce_spd;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bubble_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bubble_motion_ctrl
// Description : Per-bubble motion FSM feeding position and size to the
//               square drawing object; handles bounces, splits and pops.
// Revision    : 1.0 - initial release
// ============================================================================
module bubble_motion_ctrl
    import bubble_pkg::*;
#(
    parameter int X_SPEED      = 64,
    parameter int GRAVITY      = 4,
    parameter int MAX_FALL     = 512,
    parameter int POP_JUMP     = 192,
    parameter int SCREEN_LEFT  = 0,
    parameter int SCREEN_RIGHT = 639,
    parameter int FLOOR_Y      = 440
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        spawn,
    input  logic [10:0] spawnX,
    input  logic [10:0] spawnY,
    input  logic [2:0]  spawnSize,
    input  logic        spawnDirLeft,
    input  logic        ropeHit,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [2:0]  size,
    output logic        alive,
    output logic        popped,
    output logic        splitReq,
    output logic [10:0] splitX,
    output logic [10:0] splitY,
    output logic [2:0]  splitSize
);

    localparam logic signed [POS_W-1:0] c_x_speed  = POS_W'(X_SPEED);
    localparam logic signed [POS_W-1:0] c_gravity  = POS_W'(GRAVITY);
    localparam logic signed [POS_W-1:0] c_max_fall = POS_W'(MAX_FALL);
    localparam logic signed [POS_W-1:0] c_pop_jump = POS_W'(POP_JUMP);
    localparam logic signed [POS_W-1:0] c_left_fx  = POS_W'(SCREEN_LEFT << FIXED_SHIFT);
    localparam logic signed [POS_W-1:0] c_right_fx = POS_W'((SCREEN_RIGHT + 1) << FIXED_SHIFT);
    localparam logic signed [POS_W-1:0] c_floor_fx = POS_W'(FLOOR_Y << FIXED_SHIFT);
    localparam logic signed [POS_W-1:0] c_zero     = '0;
    localparam logic [2:0]              c_max_size = 3'(MAX_SIZE);

    state_t                  r_state;
    logic signed [POS_W-1:0] r_x_pos, r_y_pos, r_x_spd, r_y_spd;
    logic [2:0]              r_size;
    logic                    r_alive, r_popped, r_split_req;
    logic [10:0]             r_split_x, r_split_y;
    logic [2:0]              r_split_size;

    logic signed [POS_W-1:0] w_edge_fx, w_x_hi, w_y_hi, w_x_bounce, w_y_bounce;
    logic signed [POS_W-1:0] w_x_pos_next, w_x_spd_next, w_y_pos_next, w_y_spd_next;
    logic [2:0]              w_spawn_size;

    assign w_edge_fx    = POS_W'(edge_px(r_size)) << FIXED_SHIFT;
    assign w_x_hi       = c_right_fx - w_edge_fx;
    assign w_y_hi       = c_floor_fx - w_edge_fx;
    assign w_x_bounce   = -r_x_spd;
    assign w_y_bounce   = -bounce_speed(r_size);
    assign w_spawn_size = (spawnSize > c_max_size) ? c_max_size : spawnSize;

    bubble_axis_step #(
        .HI_INCLUSIVE (1'b0)
    ) u_x_step (
        .i_pos           (r_x_pos),
        .i_spd           (r_x_spd),
        .i_accel         (c_zero),
        .i_max_spd       (c_x_speed),
        .i_lo            (c_left_fx),
        .i_hi            (w_x_hi),
        .i_hi_bounce_spd (w_x_bounce),
        .o_pos_next      (w_x_pos_next),
        .o_spd_next      (w_x_spd_next)
    );

    // The floor counts as touched when the bottom edge reaches it, hence inclusive.
    bubble_axis_step #(
        .HI_INCLUSIVE (1'b1)
    ) u_y_step (
        .i_pos           (r_y_pos),
        .i_spd           (r_y_spd),
        .i_accel         (c_gravity),
        .i_max_spd       (c_max_fall),
        .i_lo            (c_zero),
        .i_hi            (w_y_hi),
        .i_hi_bounce_spd (w_y_bounce),
        .o_pos_next      (w_y_pos_next),
        .o_spd_next      (w_y_spd_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_x_pos      <= '0;
            r_y_pos      <= '0;
            r_x_spd      <= '0;
            r_y_spd      <= '0;
            r_size       <= '0;
            r_alive      <= 1'b0;
            r_popped     <= 1'b0;
            r_split_req  <= 1'b0;
            r_split_x    <= '0;
            r_split_y    <= '0;
            r_split_size <= '0;
        end else begin
            r_popped    <= 1'b0;
            r_split_req <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (spawn) begin
                        r_x_pos <= POS_W'(spawnX) << FIXED_SHIFT;
                        r_y_pos <= POS_W'(spawnY) << FIXED_SHIFT;
                        r_x_spd <= spawnDirLeft ? -c_x_speed : c_x_speed;
                        r_y_spd <= '0;
                        r_size  <= w_spawn_size;
                        r_alive <= 1'b1;
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (ropeHit) begin
                        if (r_size == 3'd0) begin
                            r_popped <= 1'b1;
                            r_alive  <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            r_state <= SPLIT;
                        end
                    end else if (startOfFrame) begin
                        r_x_pos <= w_x_pos_next;
                        r_x_spd <= w_x_spd_next;
                        r_y_pos <= w_y_pos_next;
                        r_y_spd <= w_y_spd_next;
                    end
                end
                SPLIT: begin
                    r_size       <= r_size - 3'd1;
                    r_x_spd      <= c_x_speed;
                    r_y_spd      <= -c_pop_jump;
                    r_split_req  <= 1'b1;
                    r_split_x    <= topLeftX;
                    r_split_y    <= topLeftY;
                    r_split_size <= r_size - 3'd1;
                    r_state      <= ACTIVE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign topLeftX  = r_x_pos[FIXED_SHIFT +: 11];
    assign topLeftY  = r_y_pos[FIXED_SHIFT +: 11];
    assign size      = r_size;
    assign alive     = r_alive;
    assign popped    = r_popped;
    assign splitReq  = r_split_req;
    assign splitX    = r_split_x;
    assign splitY    = r_split_y;
    assign splitSize = r_split_size;

endmodule
`default_nettype wire

// File: tb/tb_bubble_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bubble_motion_ctrl
// Description : Scoreboard bench for bubble_motion_ctrl against a frame-level
//               physics model of the bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bubble_motion_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0, spawn = 1'b0, spawnDirLeft = 1'b0, ropeHit = 1'b0;
    logic [10:0] spawnX = '0, spawnY = '0;
    logic [2:0]  spawnSize = '0;
    logic [10:0] topLeftX, topLeftY, splitX, splitY;
    logic [2:0]  size, splitSize;
    logic        alive, popped, splitReq;

    bubble_motion_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .spawn        (spawn),
        .spawnX       (spawnX),
        .spawnY       (spawnY),
        .spawnSize    (spawnSize),
        .spawnDirLeft (spawnDirLeft),
        .ropeHit      (ropeHit),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .size         (size),
        .alive        (alive),
        .popped       (popped),
        .splitReq     (splitReq),
        .splitX       (splitX),
        .splitY       (splitY),
        .splitSize    (splitSize)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [52:0] exp_q[$];
    logic [52:0] mon_exp;

    // Bubble model: positions and speeds in 1/64 px, one step per frame.
    bit m_alive, m_pending, m_popped, m_split;
    int m_x, m_y, m_xs, m_ys, m_size, m_sx, m_sy, m_ss;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    function automatic int tl(input int p);
        return (p >>> 6) & 'h7FF;
    endfunction

    function automatic logic [52:0] m_vec();
        return {11'(tl(m_x)), 11'(tl(m_y)), 3'(m_size), m_alive, m_popped, m_split,
                11'(m_sx), 11'(m_sy), 3'(m_ss)};
    endfunction

    function automatic logic [52:0] dut_vec();
        return {topLeftX, topLeftY, size, alive, popped, splitReq, splitX, splitY, splitSize};
    endfunction

    task automatic m_reset();
        m_alive = 0; m_pending = 0; m_popped = 0; m_split = 0;
        m_x = 0; m_y = 0; m_xs = 0; m_ys = 0; m_size = 0; m_sx = 0; m_sy = 0; m_ss = 0;
    endtask

    task automatic m_frame();
        int e;
        e = 8 << m_size;
        m_x  = m_x + m_xs;
        m_y  = m_y + m_ys;
        m_ys = (m_ys + 4 > 512) ? 512 : m_ys + 4;
        if (m_y + e * 64 >= 440 * 64 && m_ys > 0) begin
            m_y  = (440 - e) * 64;
            m_ys = -(320 + 64 * m_size);
        end else if (m_y < 0 && m_ys < 0) begin
            m_y  = 0;
            m_ys = -m_ys;
        end
        if (m_x < 0 && m_xs < 0) begin
            m_x  = 0;
            m_xs = -m_xs;
        end else if (m_x + e * 64 > 640 * 64 && m_xs > 0) begin
            m_x  = (640 - e) * 64;
            m_xs = -m_xs;
        end
    endtask

    task automatic m_step(input bit sp, input int sx, input int sy, input int ssz,
                          input bit sdl, input bit sof, input bit rope);
        m_popped = 0;
        m_split  = 0;
        if (m_pending) begin
            m_size    = m_size - 1;
            m_xs      = 64;
            m_ys      = -192;
            m_split   = 1;
            m_sx      = tl(m_x);
            m_sy      = tl(m_y);
            m_ss      = m_size;
            m_pending = 0;
        end else if (!m_alive) begin
            if (sp) begin
                m_x = sx * 64; m_y = sy * 64;
                m_size = (ssz > 3) ? 3 : ssz;
                m_xs = sdl ? -64 : 64; m_ys = 0;
                m_alive = 1;
            end
        end else if (rope) begin
            if (m_size == 0) begin
                m_popped = 1;
                m_alive  = 0;
            end else begin
                m_pending = 1;
            end
        end else if (sof) begin
            m_frame();
        end
    endtask

    task automatic cycle(input bit sp, input int sx, input int sy, input int ssz,
                         input bit sdl, input bit sof, input bit rope);
        reset        = 1'b0;
        spawn        = sp;
        spawnX       = 11'(sx);
        spawnY       = 11'(sy);
        spawnSize    = 3'(ssz);
        spawnDirLeft = sdl;
        startOfFrame = sof;
        ropeHit      = rope;
        m_step(sp, sx, sy, ssz, sdl, sof, rope);
        @(posedge clk);
        exp_q.push_back(m_vec());
        #1;
        spawn = 1'b0; startOfFrame = 1'b0; ropeHit = 1'b0;
    endtask

    task automatic frame();
        cycle(0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", dut_vec(), 53'd0);
        m_reset();
        @(posedge clk);
        exp_q.push_back(m_vec());
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("outputs", dut_vec(), mon_exp);
        end
    end

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), 53'd0);

        cycle(1, 100, 100, 1, 0, 0, 0);
        check("spawn_x", topLeftX, 100);
        check("spawn_y", topLeftY, 100);
        check("spawn_size", size, 1);
        check("spawn_alive", alive, 1);
        for (int i = 1; i <= 3; i++) begin
            frame();
            check("frame_x", topLeftX, 100 + i);
            check("frame_y", topLeftY, 100);
            cycle(0, 0, 0, 0, 0, 0, 0);
        end
        repeat (200) frame();

        do_reset();
        cycle(1, 200, 150, 2, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("split_req", splitReq, 1);
        check("split_xy", {splitX, splitY}, {11'd200, 11'd150});
        check("split_size", splitSize, 1);
        check("size_after_split", size, 1);
        check("pos_after_split", {topLeftX, topLeftY}, {11'd200, 11'd150});
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("split_pulse_end", splitReq, 0);

        do_reset();
        cycle(1, 630, 100, 0, 0, 0, 0);
        repeat (3) frame();
        check("right_wall_x", topLeftX, 632);
        frame();
        check("right_wall_back", topLeftX, 631);
        repeat (700) frame();

        cycle(0, 0, 0, 0, 0, 0, 1);
        check("pop_pulse", popped, 1);
        check("pop_alive", alive, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        check("pop_once", {popped, alive}, 2'b00);

        cycle(1, 300, 50, 3, 1, 0, 0);
        repeat (20) frame();
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) == 0, $urandom_range(0, 700), $urandom_range(0, 400),
                      $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
            end
        end

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
